// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: valid/ready load port carrying the next display value
interface seg7_scan_driver_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  modport master(output load_valid, load_data, load_dp, input load_ready);
  modport slave(input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-seg scanner, frame-synchronous double buffer; SEG7_LEADING_ZERO_BLANK_EN hides leading zeros
module seg7_scan_driver #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  seg7_scan_driver_if.slave  load,
  output logic [1:0]         digit_sel,
  output logic [3:0]         anode,
  output logic [6:0]         cathode,
  output logic               dp,
  output logic               frame_tick
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      digit_q, digit_d;
  logic [3:0]      anode_q, anode_d;
  logic [6:0]      cathode_q, cathode_d;
  logic            dp_q, dp_d, frame_q;
  logic [15:0]     shadow_q, active_q;
  logic [3:0]      shadow_dp_q, active_dp_q, nib;
  logic            full_q, tick, commit, shown, drive;
  assign tick    = enable && presc_q == PW'(CLK_DIV - 1);
  assign commit  = tick && digit_q == 2'd3;
  assign presc_d = (enable && !tick) ? presc_q + PW'(1) : '0;
  assign digit_d = digit_q + 2'(tick);
  assign state_d = !enable ? BLANK :
                   tick ? (BLANK_CYCLES == 0 ? DRIVE : BLANK) :
                   (state_q == BLANK && BLANK_CYCLES != 0 && presc_q == PW'(BLANK_CYCLES - 1)) ? DRIVE :
                   state_q;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [1:0] msd;
  assign msd   = active_q[15:12] != 4'h0 ? 2'd3 :
                 active_q[11:8]  != 4'h0 ? 2'd2 :
                 active_q[7:4]   != 4'h0 ? 2'd1 : 2'd0;
  assign shown = digit_q <= msd;
`else
  assign shown = 1'b1;
`endif
  assign nib       = active_q[{digit_q, 2'b00} +: 4];
  assign drive     = enable && state_q == DRIVE && shown;
  assign anode_d   = drive ? ~(4'b0001 << digit_q) : 4'hF;
  assign cathode_d = drive ? SEG[nib] : 7'h7F;
  assign dp_d      = drive ? ~active_dp_q[digit_q] : 1'b1;
  // Slot prescaler, digit index, blank/drive FSM and registered pins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      digit_q   <= 2'd0;
      state_q   <= BLANK;
      anode_q   <= 4'hF;
      cathode_q <= 7'h7F;
      dp_q      <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      state_q   <= state_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
      dp_q      <= dp_d;
      frame_q   <= commit;
    end
  end
  // Shadow accepts only when empty; active takes it at the frame boundary so the display never tears
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q      <= 1'b0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
    end else if (load.load_valid && !full_q) begin
      shadow_q    <= load.load_data;
      shadow_dp_q <= load.load_dp;
      full_q      <= 1'b1;
    end else if (commit && full_q) begin
      active_q    <= shadow_q;
      active_dp_q <= shadow_dp_q;
      full_q      <= 1'b0;
    end
  end
  assign load.load_ready = ~full_q;
  assign digit_sel       = digit_q;
  assign anode           = anode_q;
  assign cathode         = cathode_q;
  assign dp              = dp_q;
  assign frame_tick      = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench, CLK_DIV=8, BLANK_CYCLES=2
module tb_seg7_scan_driver;
  logic       clock = 1'b0;
  logic       reset_n, enable;
  logic [1:0] digit_sel;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic       dp, frame_tick;
  int checks = 0, failures = 0;
  localparam logic [6:0] SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  seg7_scan_driver_if lif();
  seg7_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(lif),
    .digit_sel(digit_sel), .anode(anode), .cathode(cathode), .dp(dp), .frame_tick(frame_tick)
  );
  always #5 clock = ~clock;
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while (!frame_tick && n < 40);
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL %s frame_tick not seen within 40 cycles", name);
    end
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    enable = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data = 16'h0;
    lif.load_dp = 4'h0;
    cyc(3);
    reset_n = 1'b1;
    checks++;
    if ({anode, cathode, dp, lif.load_ready, digit_sel, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {anode, cathode, dp, lif.load_ready, digit_sel, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b1, 2'd0, 1'b0});
    end
    cyc(3);
    checks++;
    if ({anode, cathode, dp, digit_sel} !== {4'hE, 7'b1000000, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL reset_first_drive got=%h exp=%h", {anode, cathode, dp, digit_sel}, {4'hE, 7'b1000000, 1'b1, 2'd0});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({anode, cathode, dp, lif.load_ready, digit_sel, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", {anode, cathode, dp, lif.load_ready, digit_sel, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b1, 2'd0, 1'b0});
    end
    cyc(2);
    reset_n = 1'b1;
  endtask
  task automatic test_load;
    lif.load_valid = 1'b1;
    lif.load_data = 16'h1234;
    lif.load_dp = 4'b0001;
    cyc(1);
    checks++;
    if (lif.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL load_ready_drop got=%b exp=0", lif.load_ready);
    end
    lif.load_valid = 1'b0;
    lif.load_data = 16'h0;
    lif.load_dp = 4'h0;
    cyc(30);
    checks++;
    if ({frame_tick, lif.load_ready} !== 2'b00) begin
      failures++;
      $display("FAIL load_before_frame got=%b exp=00", {frame_tick, lif.load_ready});
    end
    cyc(1);
    checks++;
    if ({frame_tick, lif.load_ready, digit_sel} !== {1'b1, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL load_commit got=%b exp=%b", {frame_tick, lif.load_ready, digit_sel}, {1'b1, 1'b1, 2'd0});
    end
    cyc(1);
    checks++;
    if (frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL load_tick_pulse got=%b exp=0", frame_tick);
    end
    cyc(2);
    checks++;
    if ({anode, cathode, dp} !== {4'b1110, 7'b0011001, 1'b0}) begin
      failures++;
      $display("FAIL load_digit0 got=%b exp=%b", {anode, cathode, dp}, {4'b1110, 7'b0011001, 1'b0});
    end
  endtask
  task automatic test_slot_timing;
    int p = 3, k = 0, j;
    logic blank, ft_e;
    logic [3:0] ae;
    logic [6:0] ce;
    logic de;
    for (int i = 0; i < 32; i++) begin
      cyc(1);
      p = (p + 1) % 8;
      if (p == 0) k = (k + 1) % 4;
      j = (p == 0) ? (k + 3) % 4 : k;
      blank = (p == 1 || p == 2);
      ae = 4'b0001 << j;
      ae = blank ? 4'hF : ~ae;
      ce = blank ? 7'h7F : SEG[4 - j];
      de = blank ? 1'b1 : (j != 0);
      ft_e = (p == 0 && k == 0);
      checks++;
      if ({anode, cathode, dp, digit_sel, frame_tick} !== {ae, ce, de, 2'(k), ft_e}) begin
        failures++;
        $display("FAIL slot_cycle%0d got=%b exp=%b", i, {anode, cathode, dp, digit_sel, frame_tick}, {ae, ce, de, 2'(k), ft_e});
      end
    end
  endtask
  task automatic test_back_to_back;
    lif.load_valid = 1'b1;
    lif.load_data = 16'h9876;
    lif.load_dp = 4'b0000;
    cyc(1);
    checks++;
    if (lif.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got=%b exp=0", lif.load_ready);
    end
    lif.load_data = 16'hABCD;
    lif.load_dp = 4'hF;
    cyc(3);
    checks++;
    if (lif.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold got=%b exp=0", lif.load_ready);
    end
    lif.load_data = 16'h5555;
    lif.load_dp = 4'b0010;
    wait_frame("bp_frame1");
    checks++;
    if ({lif.load_ready, anode, cathode, dp} !== {1'b1, 4'b0111, 7'b1111001, 1'b1}) begin
      failures++;
      $display("FAIL bp_old_value got=%b exp=%b", {lif.load_ready, anode, cathode, dp}, {1'b1, 4'b0111, 7'b1111001, 1'b1});
    end
    cyc(1);
    checks++;
    if (lif.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_second_accept got=%b exp=0", lif.load_ready);
    end
    lif.load_valid = 1'b0;
    cyc(2);
    checks++;
    if ({anode, cathode, dp} !== {4'b1110, 7'b0000010, 1'b1}) begin
      failures++;
      $display("FAIL bp_new_d0 got=%b exp=%b", {anode, cathode, dp}, {4'b1110, 7'b0000010, 1'b1});
    end
    cyc(24);
    checks++;
    if ({anode, cathode, dp} !== {4'b0111, 7'b0010000, 1'b1}) begin
      failures++;
      $display("FAIL bp_new_d3 got=%b exp=%b", {anode, cathode, dp}, {4'b0111, 7'b0010000, 1'b1});
    end
    wait_frame("bp_frame2");
    checks++;
    if (lif.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready2 got=%b exp=1", lif.load_ready);
    end
    cyc(11);
    checks++;
    if ({anode, cathode, dp} !== {4'b1101, 7'b0010010, 1'b0}) begin
      failures++;
      $display("FAIL bp_5555_d1 got=%b exp=%b", {anode, cathode, dp}, {4'b1101, 7'b0010010, 1'b0});
    end
  endtask
  task automatic test_enable;
    int ft_n = 0, bad = 0;
    cyc(8);
    checks++;
    if ({anode, cathode, digit_sel} !== {4'b1011, 7'b0010010, 2'd2}) begin
      failures++;
      $display("FAIL en_drive_d2 got=%b exp=%b", {anode, cathode, digit_sel}, {4'b1011, 7'b0010010, 2'd2});
    end
    enable = 1'b0;
    cyc(1);
    checks++;
    if ({anode, digit_sel} !== {4'hF, 2'd2}) begin
      failures++;
      $display("FAIL en_dark got=%b exp=%b", {anode, digit_sel}, {4'hF, 2'd2});
    end
    lif.load_valid = 1'b1;
    lif.load_data = 16'h00C0;
    lif.load_dp = 4'h0;
    cyc(1);
    checks++;
    if (lif.load_ready !== 1'b0) begin
      failures++;
      $display("FAIL en_accept_disabled got=%b exp=0", lif.load_ready);
    end
    lif.load_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      ft_n += int'(frame_tick);
      bad += int'(digit_sel != 2'd2 || anode != 4'hF);
    end
    checks++;
    if (ft_n != 0) begin
      failures++;
      $display("FAIL en_no_frame_tick got=%0d exp=0", ft_n);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL en_frozen_dark got=%0d exp=0", bad);
    end
    enable = 1'b1;
    cyc(1);
    checks++;
    if (anode !== 4'hF) begin
      failures++;
      $display("FAIL en_blank1 got=%b exp=1111", anode);
    end
    cyc(1);
    checks++;
    if (anode !== 4'hF) begin
      failures++;
      $display("FAIL en_blank2 got=%b exp=1111", anode);
    end
    cyc(1);
    checks++;
    if ({anode, cathode, digit_sel, lif.load_ready} !== {4'b1011, 7'b0010010, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL en_resume got=%b exp=%b", {anode, cathode, digit_sel, lif.load_ready}, {4'b1011, 7'b0010010, 2'd2, 1'b0});
    end
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    checks++;
    if (lif.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL en_reset_ready got=%b exp=1", lif.load_ready);
    end
    wait_frame("en_frame");
    cyc(3);
    checks++;
    if ({anode, cathode, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      failures++;
      $display("FAIL en_zero_d0 got=%b exp=%b", {anode, cathode, dp}, {4'b1110, 7'b1000000, 1'b1});
    end
    cyc(8);
    checks++;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if ({anode, dp} !== {4'hF, 1'b1}) begin
      failures++;
      $display("FAIL en_zero_d1 got=%b exp=%b", {anode, dp}, {4'hF, 1'b1});
    end
`else
    if ({anode, cathode, dp} !== {4'b1101, 7'b1000000, 1'b1}) begin
      failures++;
      $display("FAIL en_zero_d1 got=%b exp=%b", {anode, cathode, dp}, {4'b1101, 7'b1000000, 1'b1});
    end
`endif
  endtask
  task automatic test_leading_zero;
    logic [3:0] a2, a3;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    a2 = 4'hF;
    a3 = 4'hF;
`else
    a2 = 4'b1011;
    a3 = 4'b0111;
`endif
    lif.load_valid = 1'b1;
    lif.load_data = 16'h0050;
    lif.load_dp = 4'h0;
    cyc(1);
    lif.load_valid = 1'b0;
    wait_frame("lz_frame");
    cyc(3);
    checks++;
    if ({anode, cathode, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      failures++;
      $display("FAIL lz_d0 got=%b exp=%b", {anode, cathode, dp}, {4'b1110, 7'b1000000, 1'b1});
    end
    cyc(8);
    checks++;
    if ({anode, cathode, dp} !== {4'b1101, 7'b0010010, 1'b1}) begin
      failures++;
      $display("FAIL lz_d1 got=%b exp=%b", {anode, cathode, dp}, {4'b1101, 7'b0010010, 1'b1});
    end
    cyc(8);
    checks++;
    if ({anode, dp} !== {a2, 1'b1}) begin
      failures++;
      $display("FAIL lz_d2 got=%b exp=%b", {anode, dp}, {a2, 1'b1});
    end
    cyc(8);
    checks++;
    if ({anode, dp} !== {a3, 1'b1}) begin
      failures++;
      $display("FAIL lz_d3 got=%b exp=%b", {anode, dp}, {a3, 1'b1});
    end
  endtask
  initial begin
    test_reset;
    test_load;
    test_slot_timing;
    test_back_to_back;
    test_enable;
    test_leading_zero;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Four-digit multiplexed seven-segment scan engine for the board display. It contains the digit-slot prescaler and the 2-bit digit index, and it drives the anode and cathode pins directly. A valid/ready port double-buffers the value to display, and new values commit only at frame boundaries so the display never tears. Hex decode and anti-ghosting blank time are built in.

Parameters:
CLK_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^24.
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range 0..CLK_DIV-1.

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning runs; 0 = display dark, scan frozen
load_valid  in  1  new display value offered
load_ready  out  1  shadow buffer empty, transfer accepted
load_data  in  16  four hex nibbles; [3:0] = digit 0 (rightmost)
load_dp  in  4  decimal points, bit i = digit i, 1 = lit
digit_sel  out  2  current digit slot index
anode  out  4  active-low digit enables, anode[i] = digit i
cathode  out  7  active-low segments, bit0=a .. bit6=g
dp  out  1  active-low decimal point
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, reset_n=0) forces: prescaler=0, digit_sel=0, FSM=BLANK, anode=4'b1111, cathode=7'h7F, dp=1, frame_tick=0, load_ready=1, shadow empty, active value=0, active dp=0. A pending shadow value is discarded.
- Prescaler: counts 0..CLK_DIV-1 while enable=1 and wraps to 0. Slot tick = (prescaler==CLK_DIV-1).
- On tick: digit_sel <= digit_sel+1 (mod 4, 3 wraps to 0). The FSM enters BLANK, or enters DRIVE directly if BLANK_CYCLES=0.
- FSM has two states:
  - BLANK: anode=1111, cathode=7F, dp=1. Transitions to DRIVE on the cycle where prescaler==BLANK_CYCLES-1.
  - DRIVE: anode has only bit digit_sel low; cathode=decode(active nibble[digit_sel]); dp=~active_dp[digit_sel]. Transitions to BLANK on tick.
- All pin outputs are registered. The pins reflect the FSM state one cycle after each state change.
- Decode, as {g..a} active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Handshake: a transfer occurs when load_valid and load_ready are both 1 at a clock edge.
  - The transfer captures load_data and load_dp into the shadow, and load_ready drops to 0 the next cycle.
  - load_data is ignored while load_ready=0.
- Commit: on the tick with digit_sel==3, if the shadow is full (value sampled before the edge), active <= shadow and the shadow empties. load_ready returns to 1 the following cycle.
- frame_tick pulses on that same tick whether or not a commit occurs.
- Simultaneous transfer and commit tick cannot collide: a transfer requires an empty shadow, so that edge commits nothing and the new value waits one full frame.
- enable=0: prescaler clears to 0, FSM goes to BLANK, digit_sel holds, and pins go dark the next cycle. There are no ticks, commits or frame_tick. The handshake still accepts one value into the shadow.
- Re-enable: scanning resumes at the held digit_sel, starting in BLANK.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined: in DRIVE, each digit above the most significant nonzero nibble of the active value keeps its anode high and dp off. Digit 0 is always shown, so a value of 0 shows a single "0". Slot timing is unchanged.
- When undefined: all four digits are always driven.

Test Plan:
All tests use CLK_DIV=8, BLANK_CYCLES=2.
1. Reset: hold reset_n=0, then release -> anode=1111, cathode=7F, dp=1, load_ready=1, digit_sel=0. Assert reset_n=0 mid-slot -> same values immediately, with no clock edge needed.
2. Load: offer 0x1234 with load_dp=0001 right after reset -> load_ready=0 the next cycle. After the digit 3->0 tick (32 cycles), frame_tick pulses, load_ready=1, and in the digit-0 DRIVE phase anode=1110, cathode=0011001, dp=0.
3. Slot timing: in each slot, pins show anode=1111 for 2 cycles and then one anode low for 6 cycles; digit_sel sequence is 0,1,2,3,0; frame_tick occurs every 32 cycles.
4. Backpressure: second valid 0xABCD offered while load_ready=0, with data changed to 0x5555 before ready returns -> only the value present at the accepting edge is captured. The display shows 0x1234 until the next frame boundary.
5. Enable: drop enable in the DRIVE phase of digit 2 -> anode=1111 the next cycle, digit_sel stays 2, and no frame_tick occurs. Raise enable -> 2 blank cycles, then anode=1011. A reset with the shadow full discards the pending value and display stays 0.
6. Macro defined: commit 0x0050 -> digit slots 3 and 2 keep anode=1111, digit 1 shows 5 (0010010), digit 0 shows 0 (1000000).
